mips_seq_controller: RTL and testbench

MIPS_SEQ_CONTROLLER -- requirements
Module: mips_seq_controller

---
 rtl/mips_seq_controller.sv | 110 +++++++++++
 tb/tb_mips_seq_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_seq_controller.sv
// mips_seq_controller: multi-cycle fetch/decode/exec/wb
// sequencer for a 12-bit MIPS-like instruction subset.
module mips_seq_controller (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        imem_ack,
  input  logic [11:0] imem_data,
  input  logic        hold,
  output logic        imem_req,
  output logic [7:0]  pc,
  output logic [11:0] ir,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        halted,
  output logic [7:0]  instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  state_t state;

  logic [2:0] op;
  logic [2:0] rt;
  logic [2:0] rd;
  logic       dec_vld;
  logic       is_r;
  logic       is_addi;
  logic       is_andi;
  logic       wr_en;

  assign op = ir[11:9];
  assign rt = ir[5:3];
  assign rd = ir[2:0];

  // Decode is only exposed once ir holds the current instruction.
  assign dec_vld = (state == DECODE) ||
                   (state == EXEC) ||
                   (state == WB);

  assign is_r    = dec_vld && !op[2];
  assign is_addi = dec_vld && (op == 3'b100);
  assign is_andi = dec_vld && (op == 3'b101);

  assign wr_en = (is_r && (rd != 3'd0)) ||
                 ((is_addi || is_andi) && (rt != 3'd0));

  always_comb begin
    alu_op  = 2'b00;
    alu_src = 1'b0;
    reg_dst = 1'b0;
    unique case (1'b1)
      is_r: begin
        alu_op  = op[1:0];
        reg_dst = 1'b1;
      end
      is_addi: begin
        alu_op  = 2'b00;
        alu_src = 1'b1;
      end
      is_andi: begin
        alu_op  = 2'b10;
        alu_src = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign halted    = (state == HALT);
  assign reg_write = (state == WB) && !hold && wr_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= 8'h00;
      ir          <= 12'h000;
      instr_count <= 8'h00;
    end else if (!hold) begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            state <= DECODE;
          end
        end
        DECODE: state <= (op == 3'b111) ? HALT : EXEC;
        EXEC:   state <= WB;
        WB: begin
          pc    <= pc + 8'd1;
          state <= FETCH;
          if (instr_count != 8'hFF)
            instr_count <= instr_count + 8'd1;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_seq_controller.sv
// Bench for mips_seq_controller: directed scenarios plus
// randomized traffic against a behavioural instruction model.
module tb_mips_seq_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [11:0] imem_data = 12'h000;
  logic        hold = 1'b0;
  logic        imem_req;
  logic [7:0]  pc;
  logic [11:0] ir;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        reg_dst;
  logic        reg_write;
  logic        halted;
  logic [7:0]  instr_count;

  mips_seq_controller dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .hold        (hold),
    .imem_req    (imem_req),
    .pc          (pc),
    .ir          (ir),
    .alu_op      (alu_op),
    .alu_src     (alu_src),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  localparam logic [11:0] I_ADD   = 12'b000_001_010_011;
  localparam logic [11:0] I_ADD0  = 12'b000_001_010_000;
  localparam logic [11:0] I_ADDI  = 12'b100_000_101_111;
  localparam logic [11:0] I_NOP   = 12'b110_000_000_000;
  localparam logic [11:0] I_HALT  = 12'b111_000_000_000;

  int npass = 0;
  int ntot  = 0;

  // Model: instruction phase is the number of cycles spent
  // since reset in terms of the instruction life cycle:
  // 0 waiting to start, 1 fetching, 2..4 cycles after the
  // fetch was accepted, 5 stopped on HALT.
  int         m_ph;
  logic [7:0] m_pc;
  int         m_cnt;
  logic [11:0] m_ir;

  task automatic chk(input string nm, input int got,
                     input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  nm, got, exp, $time);
  endtask

  function automatic bit m_writes(input logic [11:0] w);
    int o;
    o = int'(w[11:9]);
    if (o < 4) return w[2:0] != 3'd0;
    if (o == 4 || o == 5) return w[5:3] != 3'd0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ph  = 0;
    m_pc  = 8'h00;
    m_cnt = 0;
    m_ir  = 12'h000;
  endtask

  task automatic model_step();
    if (!reset_n || hold) return;
    case (m_ph)
      0: m_ph = 1;
      1: if (imem_ack) begin
        m_ir = imem_data;
        m_ph = 2;
      end
      2: m_ph = (m_ir[11:9] == 3'b111) ? 5 : 3;
      3: m_ph = 4;
      4: begin
        m_pc  = m_pc + 8'd1;
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        m_ph  = 1;
      end
      default: m_ph = 5;
    endcase
  endtask

  task automatic compare_all();
    int  o;
    bit  v;
    int  eop;
    bit  esrc;
    bit  edst;
    o    = int'(m_ir[11:9]);
    v    = (m_ph >= 2) && (m_ph <= 4);
    eop  = 0;
    esrc = 0;
    edst = 0;
    if (v) begin
      if (o < 4) begin
        eop  = o;
        edst = 1;
      end else if (o == 4) begin
        esrc = 1;
      end else if (o == 5) begin
        eop  = 2;
        esrc = 1;
      end
    end
    chk("imem_req", imem_req, int'(m_ph == 1));
    chk("halted", halted, int'(m_ph == 5));
    chk("pc", pc, m_pc);
    chk("ir", ir, m_ir);
    chk("instr_count", instr_count, m_cnt);
    chk("alu_op", alu_op, eop);
    chk("alu_src", alu_src, esrc);
    chk("reg_dst", reg_dst, edst);
    chk("reg_write", reg_write,
        int'(m_ph == 4 && !hold && m_writes(m_ir)));
  endtask

  // Called just after a falling edge; ends after the next one.
  task automatic cyc(input logic a, input logic [11:0] d,
                     input logic h);
    imem_ack  = a;
    imem_data = d;
    hold      = h;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_reset();
    imem_ack = 1'b0;
    hold     = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    compare_all();
    reset_n = 1'b1;
  endtask

  task automatic run_instr(input logic [11:0] w,
                           output int wsum);
    wsum = 0;
    cyc(1'b1, w, 1'b0);
    cyc(1'b0, 12'h000, 1'b0);
    cyc(1'b0, 12'h000, 1'b0);
    wsum += int'(reg_write);
    cyc(1'b0, 12'h000, 1'b0);
  endtask

  initial begin
    int n;
    int ws;
    int wtot;
    logic [11:0] d;
    model_reset();
    @(negedge clock);

    // Single ADD with ack always high
    do_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_dst", reg_dst, 0);
    cyc(1'b1, I_ADD, 1'b0);
    chk("add_req_first", imem_req, 1);
    cyc(1'b1, I_ADD, 1'b0);
    chk("add_dec_op", alu_op, 0);
    chk("add_dec_dst", reg_dst, 1);
    cyc(1'b1, I_ADD, 1'b0);
    chk("add_exec_wr", reg_write, 0);
    cyc(1'b1, I_ADD, 1'b0);
    chk("add_wb_wr", reg_write, 1);
    chk("add_wb_pc", pc, 8'h00);
    cyc(1'b0, I_ADD, 1'b0);
    chk("add_pc", pc, 8'h01);
    chk("add_cnt", instr_count, 1);

    // ADDI with ack delayed three cycles
    do_reset();
    cyc(1'b0, I_ADDI, 1'b0);
    n = 0;
    repeat (3) begin
      n += int'(imem_req);
      cyc(1'b0, I_ADDI, 1'b0);
    end
    n += int'(imem_req);
    cyc(1'b1, I_ADDI, 1'b0);
    n += int'(imem_req);
    chk("addi_req_cycles", n, 4);
    chk("addi_src", alu_src, 1);
    chk("addi_dst", reg_dst, 0);
    cyc(1'b0, 12'h000, 1'b0);
    cyc(1'b0, 12'h000, 1'b0);
    chk("addi_wb_wr", reg_write, 1);

    // ADD to r0 then NOP: no writes
    do_reset();
    cyc(1'b0, 12'h000, 1'b0);
    run_instr(I_ADD0, ws);
    wtot = ws;
    run_instr(I_NOP, ws);
    wtot += ws;
    chk("r0nop_writes", wtot, 0);
    chk("r0nop_pc", pc, 8'h02);
    chk("r0nop_cnt", instr_count, 2);

    // Hold during EXEC, then reset mid-fetch with ack high
    do_reset();
    cyc(1'b0, 12'h000, 1'b0);
    cyc(1'b1, I_ADD, 1'b0);
    cyc(1'b0, 12'h000, 1'b0);
    repeat (3) begin
      cyc(1'b1, 12'hFFF, 1'b1);
      chk("hold_wr", reg_write, 0);
      chk("hold_ir", ir, I_ADD);
      chk("hold_op", alu_op, 0);
    end
    cyc(1'b0, 12'h000, 1'b0);
    chk("hold_wb_wr", reg_write, 1);
    cyc(1'b0, 12'h000, 1'b0);
    chk("hold_fetch_req", imem_req, 1);
    imem_ack  = 1'b1;
    imem_data = I_ADDI;
    reset_n   = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    compare_all();
    chk("midfetch_ir", ir, 0);
    chk("midfetch_req", imem_req, 0);
    chk("midfetch_pc", pc, 0);
    reset_n = 1'b1;

    // HALT freezes everything until reset
    do_reset();
    cyc(1'b0, 12'h000, 1'b0);
    run_instr(I_NOP, ws);
    cyc(1'b1, I_HALT, 1'b0);
    chk("halt_dec", halted, 0);
    cyc(1'b1, I_ADD, 1'b0);
    chk("halt_on", halted, 1);
    n = 0;
    repeat (10) begin
      cyc(1'b1, I_ADD, 1'b0);
      n += int'(imem_req) + int'(reg_write);
    end
    chk("halt_quiet", n, 0);
    chk("halt_pc", pc, 8'h01);
    chk("halt_cnt", instr_count, 1);
    do_reset();
    chk("halt_rst", halted, 0);
    chk("halt_rst_pc", pc, 0);

    // pc wrap and counter saturation
    cyc(1'b0, 12'h000, 1'b0);
    repeat (255) run_instr(I_NOP, ws);
    chk("wrap_pc_ff", pc, 8'hFF);
    chk("wrap_cnt_ff", instr_count, 8'hFF);
    run_instr(I_NOP, ws);
    chk("wrap_pc_00", pc, 8'h00);
    chk("sat_cnt", instr_count, 8'hFF);
    run_instr(I_NOP, ws);
    chk("sat_cnt2", instr_count, 8'hFF);
    chk("wrap_pc_01", pc, 8'h01);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        d = 12'($urandom);
        if (d[11:9] == 3'b111 && $urandom_range(0, 7) != 0)
          d[11:9] = 3'b110;
        cyc(1'($urandom_range(0, 1)), d,
            1'($urandom_range(0, 9) == 0));
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
